// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes match the Execute-stage opE field; states are plain 2-bit constants.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUN     = 2'b01;
  localparam logic [1:0] FIX     = 2'b10;
  localparam logic [1:0] FASTMUL = 2'b11;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; a zero divisor yields quotient bit 1 and a pass-through remainder.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, dvsr_i};
  assign q_o     = (shifted >= {1'b0, dvsr_i});
  assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; WIDTH+1 cycles start-to-done, busy stalls the pipe.
// MDU_FAST_MUL_EN: multiplies complete in one cycle through the FASTMUL state; divides stay iterative.
// startE/hiwe/lowe are only honoured while idle; cancelE drops the in-flight op without touching HI/LO.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0]   opnd_q,    opnd_d;
  logic               is_div_q,  is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q,      dz_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic               done_q,    done_d;

  logic               signed_op;
  logic               div_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign signed_op = (opE == MDU_MULT) || (opE == MDU_DIV);
  assign div_op    = opE[1];
  assign a_mag     = (signed_op && srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
  assign b_mag     = (signed_op && srcbE[WIDTH-1]) ? (~srcbE + 1'b1) : srcbE;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_acc;

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i  (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i  (acc_q[WIDTH-1]),
    .dvsr_i (opnd_q),
    .rem_o  (rem_nxt),
    .q_o    (q_bit)
  );

  assign div_acc = {rem_nxt, acc_q[WIDTH-2:0], q_bit};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  // A zero divisor forces all-ones quotient; the remainder path already holds |dividend|.
  assign quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_fix;

  assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
  assign fast_fix  = neg_res_q ? -fast_prod : fast_prod;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hiwe) hi_d = wd;
        if (lowe) lo_d = wd;
        if (startE && !cancelE) begin
          is_div_d  = div_op;
          neg_res_d = signed_op && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          neg_rem_d = signed_op && srcaE[WIDTH-1];
          dz_d      = div_op && (srcbE == '0);
          cnt_d     = '0;
          opnd_d    = div_op ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
          state_d   = RUN;
`ifdef MDU_FAST_MUL_EN
          if (!div_op) state_d = FASTMUL;
`endif
        end
      end

      RUN: begin
        if (cancelE) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_acc : mul_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!cancelE) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end

      FASTMUL: begin
        state_d = IDLE;
`ifdef MDU_FAST_MUL_EN
        if (!cancelE) begin
          hi_d   = fast_fix[2*WIDTH-1:WIDTH];
          lo_d   = fast_fix[WIDTH-1:0];
          done_d = 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): directed corner cases plus random ops vs. an arithmetic model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancelE;
  logic        hiwe;
  logic        lowe;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .startE  (startE),
    .opE     (opE),
    .srcaE   (srcaE),
    .srcbE   (srcbE),
    .cancelE (cancelE),
    .hiwe    (hiwe),
    .lowe    (lowe),
    .wd      (wd),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          qq = sa / sb;
          rr = sa % sb;
          r  = {rr[31:0], qq[31:0]};
        end
      end
      default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [1:0] op);
`ifdef MDU_FAST_MUL_EN
    return op[1] ? 33 : 1;
`else
    return (op == 2'b00) ? 33 : 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] c [4];
    c[0] = 32'h0; c[1] = 32'hFFFF_FFFF; c[2] = 32'h8000_0000; c[3] = 32'h1;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    if ($urandom_range(0, 2) == 0) return $urandom_range(0, 20);
    return $urandom;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the start edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    @(negedge clk);
    startE = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("done_clear_after_start", done, 1'b0);
  endtask

  task automatic finish_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int elapsed);
    int n = elapsed;
    int bad_busy = 0;
    logic [63:0] exp;
    while (!done && n < 200) begin
      if (!busy) bad_busy++;
      @(negedge clk);
      n++;
    end
    exp = model(op, a, b);
    chk("latency", n, lat(op));
    chk("busy_held", bad_busy, 0);
    chk("busy_at_done", busy, 1'b0);
    chk("hi_result", hi, exp[63:32]);
    chk("lo_result", lo, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    launch(op, a, b);
    finish_op(op, a, b, 0);
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb, wv;

    reset = 1'b1; startE = 1'b0; opE = '0; srcaE = '0; srcbE = '0;
    cancelE = 1'b0; hiwe = 1'b0; lowe = 1'b0; wd = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corners
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, -32'sd7, 32'd6);
    run_op(2'b10, -32'sd7, 32'd2);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0);
    run_op(2'b01, 32'd3, 32'd5);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);

    // MTHI / MTLO
    wv = $urandom; hiwe = 1'b1; wd = wv;
    @(negedge clk);
    hiwe = 1'b0;
    chk("mthi", hi, wv);
    chk("mthi_lo_kept", lo, m_lo);
    m_hi = wv;
    wv = $urandom; lowe = 1'b1; wd = wv;
    @(negedge clk);
    lowe = 1'b0;
    chk("mtlo", lo, wv);
    m_lo = wv;

    // Cancel during RUN
    launch(2'b11, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    cancelE = 1'b1;
    @(negedge clk);
    cancelE = 1'b0;
    chk("cancel_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("cancel_no_done", seen, 0);
    chk("cancel_hi_kept", hi, m_hi);
    chk("cancel_lo_kept", lo, m_lo);

    // cancelE overrides startE in IDLE
    startE = 1'b1; cancelE = 1'b1; opE = 2'b11; srcaE = 32'd9; srcbE = 32'd3;
    @(negedge clk);
    startE = 1'b0; cancelE = 1'b0;
    chk("idle_cancel_wins", busy, 1'b0);

    // Stray start and MTHI while busy are dropped
    launch(2'b11, 32'd123456, 32'd789);
    repeat (4) @(negedge clk);
    startE = 1'b1; opE = 2'b00; srcaE = 32'd2; srcbE = 32'd2;
    @(negedge clk);
    startE = 1'b0; hiwe = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    hiwe = 1'b0;
    finish_op(2'b11, 32'd123456, 32'd789, 6);

    // MTHI together with start: lands now, result overwrites later
    wv = $urandom;
    startE = 1'b1; opE = 2'b10; srcaE = 32'd77; srcbE = -32'sd5; hiwe = 1'b1; wd = wv;
    @(negedge clk);
    startE = 1'b0; hiwe = 1'b0;
    chk("mthi_with_start", hi, wv);
    finish_op(2'b10, 32'd77, -32'sd5, 0);

    // Reset mid-operation
    launch(2'b10, 32'h7654_3210, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset_hi", hi, 0);
    chk("midrun_reset_lo", lo, 0);
    chk("midrun_reset_busy", busy, 0);
    m_hi = '0; m_lo = '0;

    // Random back-to-back traffic
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb);
    end
    @(negedge clk);
    chk("final_done_low", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
